// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider, also used by the decoder and
// write-back select logic.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

  // op[1] selects remainder, op[0] selects unsigned
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  logic [N:0]   shifted;
  logic [N-1:0] trial;

  // The difference is always below the divisor when kept, so N bits suffice.
  always_comb begin
    shifted = {rem, quo[N-1]};
    trial   = shifted[N-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_next = trial;
      quo_next = {quo[N-2:0], 1'b1};
    end else begin
      rem_next = shifted[N-1:0];
      quo_next = {quo[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit: sign-magnitude conversion on accept,
// N restoring iterations, then a sign fix-up cycle before the done pulse.
module div_unit
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  div_state_e    state, state_next;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem_r, quo_r, div_r;
  logic          rem_op, neg_q, neg_r;
  logic [N-1:0]  step_rem, step_quo;

  logic          accept, is_signed, div_zero, overflow, special;
  logic [N-1:0]  abs_dividend, abs_divisor, special_val, fix_sel, fix_val;

  always_comb begin
    is_signed    = op_is_signed(op);
    abs_dividend = (is_signed && dividend[N-1]) ? -dividend : dividend;
    abs_divisor  = (is_signed && divisor[N-1])  ? -divisor  : divisor;
    div_zero     = (divisor == '0);
    overflow     = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    special      = div_zero || overflow;
    if (div_zero) special_val = op_is_rem(op) ? dividend : '1;
    else          special_val = op_is_rem(op) ? '0 : MIN_NEG;
    fix_sel      = rem_op ? rem_r : quo_r;
    fix_val      = (rem_op ? neg_r : neg_q) ? -fix_sel : fix_sel;
  end

  // Next-state logic; flush overrides everything including a same-cycle start.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      DIV_IDLE, DIV_DONE: begin
        state_next = DIV_IDLE;
        if (start) begin
          accept     = 1'b1;
          state_next = special ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN:  if (cnt == '0) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_DONE;
      default:  state_next = DIV_IDLE;
    endcase
    if (flush) begin
      accept     = 1'b0;
      state_next = DIV_IDLE;
    end
    busy = (state == DIV_RUN) || (state == DIV_FIX);
    done = (state == DIV_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_next;
  end

  div_step #(.N(N)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (div_r),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      div_r  <= '0;
      rem_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      cnt    <= CW'(N - 1);
      rem_r  <= '0;
      quo_r  <= abs_dividend;
      div_r  <= abs_divisor;
      rem_op <= op_is_rem(op);
      neg_q  <= is_signed && (dividend[N-1] ^ divisor[N-1]);
      neg_r  <= is_signed && dividend[N-1];
      if (special) result <= special_val;
    end else if (!flush && state == DIV_RUN) begin
      rem_r <= step_rem;
      quo_r <= step_quo;
      cnt   <= cnt - 1'b1;
    end else if (!flush && state == DIV_FIX) begin
      result <= fix_val;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random ops against an
// arithmetic reference model, and hand-written flush/reset/back-to-back sequences.
module tb_div_unit;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit #(.N(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  // RISC-V division semantics from plain 64-bit arithmetic (truncating toward zero)
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    case (o)
      OP_DIVU: return a / b;
      OP_REMU: return a % b;
      OP_DIV:  return 32'(sa / sb);
      default: return 32'(sa % sb);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] res, output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic check_output(input string name, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int lat, bc;
    @(negedge clk);
    apply_stimulus(o, a, b);
    wait_done(res, lat, bc);
    check({name, " result"}, res, exp_res);
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy cycles"}, bc, exp_lat - 1);
  endtask

  initial begin
    logic [31:0] res, a, b, prior;
    logic [1:0]  o;
    int lat, bc, sel;
    bit saw_done;

    // Directed vectors: {op, dividend, divisor, expected result, latency}
    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,        32'd14,         34});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,        32'd2,          34});
    vecs.push_back('{OP_DIV,  32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2,  34});
    vecs.push_back('{OP_REM,  32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE,  34});
    vecs.push_back('{OP_REM,  32'd100,        32'hFFFF_FFF9, 32'd2,         34});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,        32'hFFFF_FFFF,  1});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB,  1});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  34});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd1,        32'h8000_0000,  34});
    vecs.push_back('{OP_DIVU, 32'd7,          32'd100,      32'd0,          34});
    vecs.push_back('{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0000, 32'h7FFF_FFFF, 34});

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      check_output($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      a = (sel == 0) ? 32'h8000_0000 : $urandom;
      b = (sel == 1) ? 32'd0 : (sel == 2) ? 32'hFFFF_FFFF : (sel == 3) ? 32'($urandom_range(1, 20)) : $urandom;
      if (sel == 0) b = 32'hFFFF_FFFF;
      check_output($sformatf("rand%0d", i), o, a, b, model(o, a, b),
                   (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34);
    end

    // Flush mid-RUN together with a start; nothing must complete and result holds.
    check_output("pre-flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    prior = 32'd14;
    @(negedge clk);
    apply_stimulus(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = OP_DIVU; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("flush no activity", saw_done, 0);
    check("flush result held", result, prior);
    flush = 1'b1; start = 1'b1; op = OP_DIVU; dividend = 32'd0; divisor = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush beats start done", done, 0);
    check("flush beats start busy", busy, 0);
    check("flush beats start result", result, prior);
    check_output("after flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Start while busy is ignored.
    @(negedge clk);
    apply_stimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    apply_stimulus(OP_DIVU, 32'd9, 32'd3);
    wait_done(res, lat, bc);
    check("busy start result", res, 32'd14);
    check("busy start latency", lat, 34 - 5);
    @(negedge clk);
    check("busy start no second done", done, 0);
    check("busy start idle", busy, 0);

    // Back-to-back: start accepted during the DONE cycle.
    apply_stimulus(OP_DIVU, 32'd100, 32'd7);
    wait_done(res, lat, bc);
    check("b2b first result", res, 32'd14);
    apply_stimulus(OP_REMU, 32'd100, 32'd7);
    check("b2b busy", busy, 1);
    wait_done(res, lat, bc);
    check("b2b second result", res, 32'd2);
    check("b2b second latency", lat, 34);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    apply_stimulus(OP_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check("mid reset result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("post reset quiet", saw_done, 0);
    check_output("post reset op", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle integer divider implementing RISC-V M-extension DIV/DIVU/REM/REMU semantics.
- Sits in EX, upstream of the write-back 4:1 select mux; its result drives that mux's i3 input.
- The pipeline controller stalls on busy and captures result on the done pulse.
- Restoring radix-2 algorithm, one quotient bit per cycle.

Parameters:
N, 32, operand/result width in bits (must be >= 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
op  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU
dividend  input  N  rs1 operand, sampled on accepted start
divisor  input  N  rs2 operand, sampled on accepted start
flush  input  1  synchronous abort from pipeline (branch/exception)
busy  output  1  high while in RUN or FIX
done  output  1  one-cycle pulse; result valid
result  output  N  quotient or remainder; holds until next completion

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, internal regs=0. Applies mid-operation; the operation is discarded.
- States: IDLE, RUN, FIX, DONE. busy=1 in RUN/FIX only. done=1 in DONE only.
- Start accepted when state is IDLE or DONE and flush=0. Start while busy is ignored, with no side effects.
- On accept, latch op and operands:
  - Signed ops: take |dividend| and |divisor|, record neg_q = sign(dividend) XOR sign(divisor), and neg_r = sign(dividend).
  - Unsigned ops: neg_q = neg_r = 0.
- Special cases, resolved at accept (next state DONE, latency 1: done high the cycle after start):
  - divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend unchanged.
  - DIV/REM with dividend==2^(N-1) and divisor==all ones (overflow): DIV -> 2^(N-1); REM -> 0.
- Normal path: next state RUN, iteration counter loaded with N-1.
  - RUN, each cycle: shift {rem,quo} left by 1; trial = rem - divisor (N+1 bits). If trial is non-negative, rem=trial and quo LSB=1; else quo LSB=0.
  - Counter decrements each cycle; after N iterations go to FIX.
- FIX: select quo or rem per op, then two's-complement negate if neg_q (quotient ops) or neg_r (remainder ops). Write result; go to DONE.
- Latency: start cycle at edge k -> done high in the cycle after edge k+N+1, i.e. N+2 cycles (34 for N=32).
- DONE: lasts exactly one cycle; then IDLE, or RUN/DONE if a new start is accepted in that cycle (back-to-back allowed).
- flush=1: next state IDLE, no done pulse, result unchanged. Flush beats a same-cycle start. Flush in DONE suppresses nothing already pulsed.
- result changes only on the FIX->DONE edge or a special-case accept. It is stable between done pulses.
- Arithmetic: all internal datapaths unsigned N or N+1 bits. Negation is modulo 2^N.

Decomposition:
- Shared package div_pkg:
  - op encodings DIV_OP_DIV=2'b00, DIV_OP_DIVU=2'b01, DIV_OP_REM=2'b10, DIV_OP_REMU=2'b11
  - state encoding DIV_IDLE/DIV_RUN/DIV_FIX/DIV_DONE
  - these are shared with the decoder and write-back select logic.
- One natural sub-module: div_step (combinational single restoring iteration: inputs rem, quo, divisor; outputs next rem, next quo). Instantiated once.

Test Plan:
- DIVU 100/7, N=32 -> busy high 33 cycles, done 34 cycles after start, result=14; REMU same operands -> 2.
- DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2(-14); REM same operands -> 0xFFFFFFFE(-2); REM 100/0xFFFFFFF9(-7) -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFFB/0 -> 0xFFFFFFFB; both done 1 cycle after start, busy never high.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; latency 1.
- Flush at cycle 10 of RUN -> busy low next cycle, no done, result keeps prior value. Start in the same cycle as flush is ignored. Fresh DIVU 9/3 then -> 3.
- rst_n low mid-RUN for 1 cycle -> busy/done/result 0 immediately. Start while busy is ignored (first result intact). Back-to-back start in DONE cycle -> second done exactly 34 cycles later.
